// File: rtl/galvo_raster_seq.sv
// Raster-scan sequencer: steps the galvo over an H/V grid, handshaking each
// SPI move, settle delay and pixel acquisition in the clk_adc domain.
module galvo_raster_seq #(
   parameter int unsigned POS_W    = 11,
   parameter int unsigned SETTLE_W = 12,
   parameter int unsigned TIMEOUT  = 65535
) (
   input  logic                clk_adc,
   input  logic                rst_adc,
   input  logic                start,
   input  logic                abort,
   input  logic [POS_W-1:0]    h_start,
   input  logic [POS_W-1:0]    h_stop,
   input  logic [POS_W-1:0]    h_step,
   input  logic [POS_W-1:0]    v_start,
   input  logic [POS_W-1:0]    v_stop,
   input  logic [POS_W-1:0]    v_step,
   input  logic [SETTLE_W-1:0] settle_cycles,
   input  logic                galvo_spi_done,
   input  logic                pixel_done,
   output logic [POS_W-1:0]    galvoh,
   output logic [POS_W-1:0]    galvov,
   output logic                galvo_go,
   output logic                pixel_go,
   output logic                busy,
   output logic                line_done,
   output logic                frame_done,
   output logic                timeout_err,
   output logic [21:0]         pixel_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MOVE,
      S_WAIT_SPI,
      S_SETTLE,
      S_WAIT_PIX,
      S_ADVANCE
   } state_t;

   localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

   state_t              state_q;
   logic [POS_W-1:0]    h_start_q, h_stop_q, h_step_q;
   logic [POS_W-1:0]    v_stop_q, v_step_q;
   logic [SETTLE_W-1:0] settle_q, settle_cnt_q;
   logic [15:0]         wd_q;
   logic [POS_W-1:0]    galvoh_q, galvov_q;
   logic                galvo_go_q, pixel_go_q, busy_q;
   logic                line_done_q, frame_done_q, timeout_err_q;
   logic [21:0]         pixel_count_q;

   logic [POS_W:0]      next_h, next_v;
   logic [15:0]         wd_d;
   logic                wd_expired;

   // One extra bit so a carry out of POS_W always compares above the stop value.
   assign next_h     = {1'b0, galvoh_q} + {1'b0, h_step_q};
   assign next_v     = {1'b0, galvov_q} + {1'b0, v_step_q};
   assign wd_d       = wd_q + 16'd1;
   assign wd_expired = (wd_d == TIMEOUT_L);

   always_ff @(posedge clk_adc or posedge rst_adc) begin
      if (rst_adc) begin
         state_q       <= S_IDLE;
         h_start_q     <= '0;
         h_stop_q      <= '0;
         h_step_q      <= '0;
         v_stop_q      <= '0;
         v_step_q      <= '0;
         settle_q      <= '0;
         settle_cnt_q  <= '0;
         wd_q          <= '0;
         galvoh_q      <= '0;
         galvov_q      <= '0;
         galvo_go_q    <= 1'b0;
         pixel_go_q    <= 1'b0;
         busy_q        <= 1'b0;
         line_done_q   <= 1'b0;
         frame_done_q  <= 1'b0;
         timeout_err_q <= 1'b0;
         pixel_count_q <= '0;
      end else begin
         galvo_go_q   <= 1'b0;
         pixel_go_q   <= 1'b0;
         line_done_q  <= 1'b0;
         frame_done_q <= 1'b0;
         if (abort && (state_q != S_IDLE)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start) begin
                     h_start_q     <= h_start;
                     h_stop_q      <= h_stop;
                     h_step_q      <= (h_step == '0) ? POS_W'(1) : h_step;
                     v_stop_q      <= v_stop;
                     v_step_q      <= (v_step == '0) ? POS_W'(1) : v_step;
                     settle_q      <= settle_cycles;
                     galvoh_q      <= h_start;
                     galvov_q      <= v_start;
                     pixel_count_q <= '0;
                     timeout_err_q <= 1'b0;
                     busy_q        <= 1'b1;
                     state_q       <= S_MOVE;
                  end
               end
               S_MOVE: begin
                  galvo_go_q <= 1'b1;
                  wd_q       <= '0;
                  state_q    <= S_WAIT_SPI;
               end
               S_WAIT_SPI: begin
                  if (galvo_spi_done) begin
                     settle_cnt_q <= settle_q;
                     state_q      <= S_SETTLE;
                  end else if (wd_expired) begin
                     timeout_err_q <= 1'b1;
                     busy_q        <= 1'b0;
                     state_q       <= S_IDLE;
                  end else begin
                     wd_q <= wd_d;
                  end
               end
               S_SETTLE: begin
                  if (settle_cnt_q == '0) begin
                     pixel_go_q <= 1'b1;
                     wd_q       <= '0;
                     state_q    <= S_WAIT_PIX;
                  end else begin
                     settle_cnt_q <= settle_cnt_q - SETTLE_W'(1);
                  end
               end
               S_WAIT_PIX: begin
                  if (pixel_done) begin
                     if (pixel_count_q != '1) pixel_count_q <= pixel_count_q + 22'd1;
                     state_q <= S_ADVANCE;
                  end else if (wd_expired) begin
                     timeout_err_q <= 1'b1;
                     busy_q        <= 1'b0;
                     state_q       <= S_IDLE;
                  end else begin
                     wd_q <= wd_d;
                  end
               end
               S_ADVANCE: begin
                  if (next_h <= {1'b0, h_stop_q}) begin
                     galvoh_q <= next_h[POS_W-1:0];
                     state_q  <= S_MOVE;
                  end else begin
                     line_done_q <= 1'b1;
                     if (next_v <= {1'b0, v_stop_q}) begin
                        galvoh_q <= h_start_q;
                        galvov_q <= next_v[POS_W-1:0];
                        state_q  <= S_MOVE;
                     end else begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                     end
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign galvoh      = galvoh_q;
   assign galvov      = galvov_q;
   assign galvo_go    = galvo_go_q;
   assign pixel_go    = pixel_go_q;
   assign busy        = busy_q;
   assign line_done   = line_done_q;
   assign frame_done  = frame_done_q;
   assign timeout_err = timeout_err_q;
   assign pixel_count = pixel_count_q;

endmodule

// File: tb/tb_galvo_raster_seq.sv
// Bench for galvo_raster_seq: directed and random frames against a grid-walk
// model with cycle-exact handshake timing, abort, timeout and reset checks.
module tb_galvo_raster_seq;
   localparam int unsigned POS_W    = 11;
   localparam int unsigned SETTLE_W = 12;
   localparam int          TMO      = 20;

   logic                clk_adc = 1'b0;
   logic                rst_adc = 1'b1;
   logic                start = 1'b0, abort = 1'b0;
   logic [POS_W-1:0]    h_start = '0, h_stop = '0, h_step = '0;
   logic [POS_W-1:0]    v_start = '0, v_stop = '0, v_step = '0;
   logic [SETTLE_W-1:0] settle_cycles = '0;
   logic                galvo_spi_done = 1'b0, pixel_done = 1'b0;
   logic [POS_W-1:0]    galvoh, galvov;
   logic                galvo_go, pixel_go, busy, line_done, frame_done, timeout_err;
   logic [21:0]         pixel_count;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int exp_h[$];
   int exp_v[$];
   bit exp_eol[$];

   galvo_raster_seq #(.POS_W(POS_W), .SETTLE_W(SETTLE_W), .TIMEOUT(TMO)) dut (
      .clk_adc(clk_adc), .rst_adc(rst_adc), .start(start), .abort(abort),
      .h_start(h_start), .h_stop(h_stop), .h_step(h_step),
      .v_start(v_start), .v_stop(v_stop), .v_step(v_step),
      .settle_cycles(settle_cycles), .galvo_spi_done(galvo_spi_done),
      .pixel_done(pixel_done), .galvoh(galvoh), .galvov(galvov),
      .galvo_go(galvo_go), .pixel_go(pixel_go), .busy(busy),
      .line_done(line_done), .frame_done(frame_done),
      .timeout_err(timeout_err), .pixel_count(pixel_count)
   );

   always #5 clk_adc = ~clk_adc;

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench time limit exceeded");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk_adc);
      #1;
      cyc++;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_galvoh"}, galvoh, 0);
      check({tag, "_galvov"}, galvov, 0);
      check({tag, "_count"}, pixel_count, 0);
      check({tag, "_galvo_go"}, galvo_go, 0);
      check({tag, "_pixel_go"}, pixel_go, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_line_done"}, line_done, 0);
      check({tag, "_frame_done"}, frame_done, 0);
      check({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   // Reference grid walk in plain integers; step 0 means 1, a row/frame ends
   // once the next position would exceed the stop value (or the POS_W range).
   task automatic build_model(input int hs, input int he, input int hst,
                              input int vs, input int ve, input int vst);
      int h, v, hinc, vinc;
      exp_h.delete(); exp_v.delete(); exp_eol.delete();
      hinc = (hst == 0) ? 1 : hst;
      vinc = (vst == 0) ? 1 : vst;
      v = vs;
      forever begin
         h = hs;
         forever begin
            exp_h.push_back(h);
            exp_v.push_back(v);
            if (h + hinc > he) begin
               exp_eol.push_back(1'b1);
               break;
            end
            exp_eol.push_back(1'b0);
            h += hinc;
         end
         if (v + vinc > ve) break;
         v += vinc;
      end
   endtask

   // fault_kind: 0 none, 1 abort in SETTLE, 2 SPI timeout, 3 pixel timeout
   task automatic run_frame(input int hs, input int he, input int hst,
                            input int vs, input int ve, input int vst,
                            input int settle, input int fault_at, input int fault_kind);
      int n, k, t0, ds, dp;
      bit last;
      build_model(hs, he, hst, vs, ve, vst);
      n = exp_h.size();
      h_start = 11'(hs); h_stop = 11'(he); h_step = 11'(hst);
      v_start = 11'(vs); v_stop = 11'(ve); v_step = 11'(vst);
      settle_cycles = 12'(settle);
      start = 1'b1;
      tick();
      start = 1'b0;
      h_start = 11'($urandom); h_stop = 11'($urandom); h_step = 11'($urandom);
      v_start = 11'($urandom); v_stop = 11'($urandom); v_step = 11'($urandom);
      settle_cycles = 12'($urandom);
      check("start_busy", busy, 1);
      check("start_h", galvoh, hs);
      check("start_v", galvov, vs);
      check("start_count", pixel_count, 0);
      check("start_terr", timeout_err, 0);
      check("start_go_early", galvo_go, 0);
      tick();
      check("first_go", galvo_go, 1);
      for (int i = 0; i < n; i++) begin
         last = (i == n - 1);
         check("pos_h", galvoh, exp_h[i]);
         check("pos_v", galvov, exp_v[i]);
         if (fault_kind == 2 && i == fault_at) begin
            t0 = cyc;
            while (cyc < t0 + TMO - 1) tick();
            check("spi_tmo_busy_pre", busy, 1);
            check("spi_tmo_err_pre", timeout_err, 0);
            tick();
            check("spi_tmo_busy", busy, 0);
            check("spi_tmo_err", timeout_err, 1);
            check("spi_tmo_fd", frame_done, 0);
            repeat (3) tick();
            check("spi_tmo_sticky", timeout_err, 1);
            return;
         end
         ds = (i == 1) ? TMO - 1 : int'($urandom_range(0, 6));
         for (int j = 0; j < ds; j++) begin
            pixel_done = (j == 0);
            start = (j == 1);
            tick();
            pixel_done = 1'b0;
            start = 1'b0;
            check("spi_wait_pixgo", pixel_go, 0);
            check("spi_wait_count", pixel_count, i);
            check("spi_wait_h", galvoh, exp_h[i]);
         end
         galvo_spi_done = 1'b1;
         k = cyc;
         tick();
         galvo_spi_done = 1'b0;
         if (fault_kind == 1 && i == fault_at) begin
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("abort_busy", busy, 0);
            for (int j = 0; j < settle + 4; j++) begin
               check("abort_pixgo", pixel_go, 0);
               check("abort_fd", frame_done, 0);
               check("abort_ld", line_done, 0);
               tick();
            end
            check("abort_count", pixel_count, i);
            check("abort_h", galvoh, exp_h[i]);
            check("abort_v", galvov, exp_v[i]);
            pixel_done = 1'b1;
            tick();
            pixel_done = 1'b0;
            tick();
            tick();
            check("abort_late_pix", pixel_count, i);
            check("abort_idle_busy", busy, 0);
            check("abort_idle_go", galvo_go, 0);
            return;
         end
         while (pixel_go !== 1'b1 && cyc < k + settle + 10) tick();
         check("pixgo_cycle", cyc, k + 2 + settle);
         if (fault_kind == 3 && i == fault_at) begin
            t0 = cyc;
            while (cyc < t0 + TMO - 1) tick();
            check("pix_tmo_busy_pre", busy, 1);
            tick();
            check("pix_tmo_busy", busy, 0);
            check("pix_tmo_err", timeout_err, 1);
            check("pix_tmo_count", pixel_count, i);
            check("pix_tmo_fd", frame_done, 0);
            check("pix_tmo_ld", line_done, 0);
            return;
         end
         dp = (i == 2) ? TMO - 1 : int'($urandom_range(0, 6));
         for (int j = 0; j < dp; j++) begin
            galvo_spi_done = (j == 0);
            tick();
            galvo_spi_done = 1'b0;
            check("pix_wait_count", pixel_count, i);
         end
         pixel_done = 1'b1;
         tick();
         pixel_done = 1'b0;
         check("count_inc", pixel_count, i + 1);
         tick();
         check("line_done", line_done, exp_eol[i]);
         check("frame_done", frame_done, last);
         check("busy_adv", busy, last ? 0 : 1);
         if (!last) begin
            check("next_h", galvoh, exp_h[i + 1]);
            check("next_v", galvov, exp_v[i + 1]);
            check("go_not_yet", galvo_go, 0);
            tick();
            check("go_next", galvo_go, 1);
         end
      end
      tick();
      check("post_frame_fd", frame_done, 0);
      check("post_frame_busy", busy, 0);
      check("post_frame_count", pixel_count, n);
   endtask

   initial begin
      int hs, he, vs, ve;
      repeat (3) tick();
      check_reset("reset");
      rst_adc = 1'b0;
      tick();

      run_frame(0, 4, 2, 10, 11, 1, 3, -1, 0);
      run_frame(0, 4, 2, 10, 11, 1, 0, -1, 0);
      run_frame(2045, 2047, 4, 0, 2, 1, 0, -1, 0);
      run_frame(100, 50, 1, 5, 3, 1, 1, -1, 0);
      run_frame(7, 9, 0, 2046, 2047, 3, 2, -1, 0);
      run_frame(0, 10, 2, 0, 3, 1, 2, 3, 1);
      run_frame(5, 5, 1, 5, 5, 1, 0, 0, 2);
      run_frame(0, 2, 1, 0, 0, 1, 1, 2, 3);

      for (int r = 0; r < 6; r++) begin
         hs = int'($urandom_range(0, 2047));
         he = hs - 2 + int'($urandom_range(0, 8));
         if (he > 2047) he = 2047;
         if (he < 0) he = 0;
         vs = int'($urandom_range(0, 2047));
         ve = vs - 1 + int'($urandom_range(0, 3));
         if (ve > 2047) ve = 2047;
         if (ve < 0) ve = 0;
         run_frame(hs, he, int'($urandom_range(0, 3)), vs, ve, int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 5)), -1, 0);
      end

      h_start = 11'd300; h_stop = 11'd310; h_step = 11'd1;
      v_start = 11'd400; v_stop = 11'd410; v_step = 11'd1;
      settle_cycles = 12'd2;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("pre_rst_go", galvo_go, 1);
      #2;
      rst_adc = 1'b1;
      #1;
      check_reset("async_rst");
      #1;
      rst_adc = 1'b0;
      tick();
      check("post_rst_busy", busy, 0);
      check("post_rst_h", galvoh, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
